// File: rtl/mem_burst_reader.sv
// Burst read sequencer: issues len consecutive reads to a 1-cycle-latency memory
// and streams the returned words through a 2-entry FIFO on a valid/ready port.
module mem_burst_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_cen,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   rem;
  logic                  inflight;
  logic [1:0]            count, count_nx;
  logic [DATA_WIDTH-1:0] tail;
  logic [2:0]            occ;
  logic                  pop, push, issue, finish, accept, empty_start;

  assign mem_wr_en = 1'b0;

  // mem_cen is decoded from registered state plus this cycle's pop so a slot
  // freed by the consumer can be reused immediately (1 word/cycle).
  always_comb begin
    pop         = out_valid & out_ready;
    push        = inflight;
    occ         = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue       = (state == READ) && (occ <= 3'd1);
    mem_cen     = ~issue;
    finish      = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
    accept      = (state == IDLE) && start && (len != '0);
    empty_start = (state == IDLE) && start && (len == '0);
    count_nx    = count + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = READ;
      READ:    if (issue && rem == 1) state_nx = DRAIN;
      DRAIN:   if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      rem       <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
    end else begin
      inflight <= issue;
      done     <= finish | empty_start;
      if (accept) begin
        mem_addr <= base_addr;
        rem      <= len;
        busy     <= 1'b1;
      end else if (issue) begin
        mem_addr <= mem_addr + 1'b1;
        rem      <= rem - 1'b1;
      end
      if (finish) busy <= 1'b0;

      // out_data is the FIFO head; tail holds the second entry.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) out_data <= mem_rdata;
          else               tail     <= mem_rdata;
        end
        2'b01: out_data <= tail;
        2'b11: begin
          if (count == 2'd1) out_data <= mem_rdata;
          else begin
            out_data <= tail;
            tail     <= mem_rdata;
          end
        end
        default: ;
      endcase
      count     <= count_nx;
      out_valid <= (count_nx != 2'd0);
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a behavioural 1-cycle memory model.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  base_addr = '0;
  logic [6:0]  len = '0;
  logic        busy, done, mem_cen, mem_wr_en, out_valid;
  logic [5:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  mem_burst_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_cen(mem_cen), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          t0;
  int          done_cyc = -1;
  bit          busy_seen, wr_seen, rule_bad;
  logic [31:0] mem [64];
  int          aq[$], ac[$], rc[$];
  logic [31:0] rq[$];

  function automatic logic [31:0] mw(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0101);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!mem_cen) mem_rdata <= mem[mem_addr];

  // Stream monitor: records issued addresses and popped words, checks stall
  // stability and the FIFO occupancy rule from an independent count.
  int          tb_cnt = 0;
  bit          infl = 0, prev_stall = 0, pop_m;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (rst) begin
      tb_cnt = 0; infl = 0; prev_stall = 0;
    end else begin
      pop_m = out_valid && out_ready;
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (!mem_cen) begin
        aq.push_back(int'(mem_addr)); ac.push_back(cyc);
        if (tb_cnt + int'(infl) - int'(pop_m) > 1) rule_bad = 1;
      end
      if (pop_m) begin rq.push_back(out_data); rc.push_back(cyc); end
      if (done) done_cyc = cyc;
      if (busy) busy_seen = 1;
      if (mem_wr_en) wr_seen = 1;
      tb_cnt = tb_cnt + int'(infl) - int'(pop_m);
      if (tb_cnt > 2) rule_bad = 1;
      infl = !mem_cen;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic clear_q();
    aq.delete(); ac.delete(); rq.delete(); rc.delete();
    done_cyc = -1; busy_seen = 0; rule_bad = 0;
  endtask

  task automatic do_start(input int b, input int l);
    @(posedge clk); #2;
    base_addr = 6'(b); len = 7'(l); start = 1'b1; t0 = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int k = 0;
    while (done_cyc < 0 && k < budget) begin
      @(posedge clk); #2;
      if (toggle) out_ready = (k % 3 == 0);
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic check_burst(input string tag, input int b, input int l, input bit timing);
    chk({tag, "_naddr"}, 64'(aq.size()), 64'(l));
    chk({tag, "_nword"}, 64'(rq.size()), 64'(l));
    for (int i = 0; i < l; i++) begin
      if (i < aq.size()) chk({tag, "_addr"}, 64'(aq[i]), 64'((b + i) % 64));
      if (i < rq.size()) chk({tag, "_data"}, 64'(rq[i]), 64'(mw((b + i) % 64)));
    end
    if (rc.size() > 0) chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(rc[rc.size()-1] + 1));
    if (timing && ac.size() > 0 && rc.size() > 0) begin
      chk({tag, "_first_issue"}, 64'(ac[0]), 64'(t0 + 1));
      chk({tag, "_first_valid"}, 64'(rc[0]), 64'(t0 + 3));
    end
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = mw(i);
    wr_seen = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cen", 64'(mem_cen), 64'd1);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;

    // 1: basic burst, full throughput
    clear_q(); do_start(5, 4);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 40, 0);
    check_burst("t1", 5, 4, 1);
    if (ac.size() == 4) chk("t1_addr_back2back", 64'(ac[3] - ac[0]), 64'd3);

    // 2: address wrap
    clear_q(); do_start(62, 4);
    wait_done("t2", 40, 0);
    check_burst("t2", 62, 4, 1);

    // 3: backpressure 1,0,0 pattern
    clear_q(); do_start(10, 8);
    wait_done("t3", 200, 1);
    check_burst("t3", 10, 8, 0);
    chk("t3_issue_rule", 64'(rule_bad), 64'd0);

    // 4: zero-length request
    clear_q(); do_start(7, 0);
    wait_done("t4", 20, 0);
    chk("t4_done_cyc", 64'(done_cyc), 64'(t0 + 1));
    chk("t4_no_access", 64'(aq.size()), 64'd0);
    chk("t4_busy_never", 64'(busy_seen), 64'd0);

    // 5a: start while busy is ignored
    clear_q(); do_start(20, 6);
    @(posedge clk); #2;
    base_addr = 6'd40; len = 7'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("t5a", 60, 0);
    check_burst("t5a", 20, 6, 1);

    // 5b: reset mid-burst with consumer stalled
    clear_q(); out_ready = 1'b0; do_start(30, 8);
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("t5b_busy", 64'(busy), 64'd0);
    chk("t5b_done", 64'(done), 64'd0);
    chk("t5b_cen", 64'(mem_cen), 64'd1);
    chk("t5b_addr", 64'(mem_addr), 64'd0);
    chk("t5b_valid", 64'(out_valid), 64'd0);
    chk("t5b_data", 64'(out_data), 64'd0);
    @(posedge clk); #2; rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    chk("t5b_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    // 5c: restart after reset
    clear_q(); do_start(3, 2);
    wait_done("t5c", 40, 0);
    check_burst("t5c", 3, 2, 1);

    // 6: full-memory burst
    clear_q(); do_start(0, 64);
    wait_done("t6", 200, 0);
    check_burst("t6", 0, 64, 1);
    if (ac.size() == 64) chk("t6_addr_span", 64'(ac[63] - ac[0]), 64'd63);
    if (rc.size() == 64) chk("t6_word_span", 64'(rc[63] - rc[0]), 64'd63);
    chk("t6_wr_en_never", 64'(wr_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
